tsn_dma_responder: RTL

Memory-side responder for one DMA channel of the TSN-NPU. It sits on the far end of a dma_req/dma_resp channel and grants one burst at a time. Write bursts push 128-bit beats into a local circular buffer; read bursts pop beats from that buffer back to the initiator. It runs entirely in the fpu_clk domain and lets the DMA channels be exercised without external DRAM.

---
 rtl/tsn_dma_responder.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/tsn_dma_responder.sv
// tsn_dma_responder: memory-side responder for one DMA channel.
// Grants one burst at a time. Write bursts push beats into a local
// circular buffer. Read bursts pop beats from that buffer back to the
// initiator. Runs entirely in the fpu_clk domain.
`timescale 1ns/1ps
module tsn_dma_responder #(
    parameter int DATA_W = 128,
    parameter int DEPTH  = 16,
    parameter int LEN_W  = 8
) (
    input  logic                     fpu_clk,
    input  logic                     reset,
    input  logic                     dma_req,
    input  logic                     dma_req_wr,
    input  logic [LEN_W-1:0]         dma_req_len,
    output logic                     dma_resp,
    input  logic                     dma_write_valid,
    input  logic [DATA_W-1:0]        dma_write_data,
    output logic                     dma_write_ready,
    output logic                     dma_read_valid,
    output logic [DATA_W-1:0]        dma_read_data,
    input  logic                     dma_read_ready,
    output logic                     dma_err,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   fill_level
);

    localparam int PTR_W = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, GRANT, WR, RD} state_t;

    state_t                 state;
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic [PTR_W:0]         count;
    logic [LEN_W-1:0]       beats_left;
    logic                   dir_wr;
    logic                   rejected;
    logic [DATA_W-1:0]      mem [DEPTH];

    logic [31:0]            req_len_u;
    logic [31:0]            count_u;
    logic                   len_bad;
    logic                   wr_fits;
    logic                   rd_fits;
    logic                   push;
    logic                   pop;
    logic                   last_beat;

    // Request qualification against the current occupancy, plus beat handshakes
    always_comb begin
        req_len_u = 32'(dma_req_len);
        count_u   = 32'(count);
        len_bad   = (req_len_u == 32'd0) || (req_len_u > 32'(DEPTH));
        wr_fits   = req_len_u <= (32'(DEPTH) - count_u);
        rd_fits   = req_len_u <= count_u;
        push      = dma_write_ready && dma_write_valid;
        pop       = dma_read_valid && dma_read_ready;
        last_beat = (beats_left == LEN_W'(1));
    end

    // Burst FSM with pointers, occupancy and registered handshake outputs
    always_ff @(posedge fpu_clk) begin
        if (reset) begin
            state           <= IDLE;
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            count           <= '0;
            beats_left      <= '0;
            dir_wr          <= 1'b0;
            rejected        <= 1'b0;
            dma_resp        <= 1'b0;
            dma_err         <= 1'b0;
            dma_write_ready <= 1'b0;
            dma_read_valid  <= 1'b0;
            busy            <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (dma_req) begin
                        if (len_bad) begin
                            // Malformed length: grant with error, no data phase
                            state    <= GRANT;
                            rejected <= 1'b1;
                            dma_resp <= 1'b1;
                            dma_err  <= 1'b1;
                            busy     <= 1'b1;
                        end else if ((dma_req_wr && wr_fits) || (!dma_req_wr && rd_fits)) begin
                            state      <= GRANT;
                            rejected   <= 1'b0;
                            dir_wr     <= dma_req_wr;
                            beats_left <= dma_req_len;
                            dma_resp   <= 1'b1;
                            dma_err    <= 1'b0;
                            busy       <= 1'b1;
                        end
                        // Otherwise stall: request is re-evaluated next cycle
                    end
                end
                GRANT: begin
                    dma_resp <= 1'b0;
                    dma_err  <= 1'b0;
                    if (rejected) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (dir_wr) begin
                        state           <= WR;
                        dma_write_ready <= 1'b1;
                    end else begin
                        state          <= RD;
                        dma_read_valid <= 1'b1;
                    end
                end
                WR: begin
                    if (push) begin
                        wr_ptr     <= wr_ptr + 1'b1;
                        count      <= count + 1'b1;
                        beats_left <= beats_left - 1'b1;
                        if (last_beat) begin
                            state           <= IDLE;
                            dma_write_ready <= 1'b0;
                            busy            <= 1'b0;
                        end
                    end
                end
                RD: begin
                    if (pop) begin
                        rd_ptr     <= rd_ptr + 1'b1;
                        count      <= count - 1'b1;
                        beats_left <= beats_left - 1'b1;
                        if (last_beat) begin
                            state          <= IDLE;
                            dma_read_valid <= 1'b0;
                            busy           <= 1'b0;
                        end
                    end
                end
                default: begin
                    state           <= IDLE;
                    dma_resp        <= 1'b0;
                    dma_err         <= 1'b0;
                    dma_write_ready <= 1'b0;
                    dma_read_valid  <= 1'b0;
                    busy            <= 1'b0;
                end
            endcase
        end
    end

    // Buffer storage; contents are left unreset since only written entries are ever read
    always_ff @(posedge fpu_clk) begin
        if (push) begin
            mem[wr_ptr] <= dma_write_data;
        end
    end

    // Read data is the head entry, forced to zero when no beat is offered
    assign dma_read_data = dma_read_valid ? mem[rd_ptr] : '0;
    assign fill_level    = count;

endmodule
